mips_multicycle_ctrl: RTL and testbench

//  Main control FSM for the multicycle MIPS datapath. Sequences one instruction over 3-5+ states.

---
 rtl/mips_multicycle_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Brief    : Main control FSM for the multicycle MIPS datapath with
//            memory-ready handshake and bounded wait. Optional macro:
//            MCCTRL_BNE_EN adds bne decoding through the BEQEX state.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
  parameter int OP_WIDTH = 6,
  parameter int WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_WIDTH-1:0] op,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pcen,
  output logic                irwrite,
  output logic                regwrite,
  output logic                memwrite,
  output logic                iord,
  output logic                memtoreg,
  output logic                regdst,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [1:0]          pcsrc,
  output logic [1:0]          aluop,
  output logic                illegal_op,
  output logic                mem_timeout,
  output logic [3:0]          state_o
);

  localparam logic [3:0] c_FETCH   = 4'd0;
  localparam logic [3:0] c_DECODE  = 4'd1;
  localparam logic [3:0] c_MEMADR  = 4'd2;
  localparam logic [3:0] c_MEMRD   = 4'd3;
  localparam logic [3:0] c_MEMWB   = 4'd4;
  localparam logic [3:0] c_MEMWR   = 4'd5;
  localparam logic [3:0] c_RTYPEEX = 4'd6;
  localparam logic [3:0] c_RTYPEWB = 4'd7;
  localparam logic [3:0] c_BEQEX   = 4'd8;
  localparam logic [3:0] c_ADDIEX  = 4'd9;
  localparam logic [3:0] c_ADDIWB  = 4'd10;
  localparam logic [3:0] c_JEX     = 4'd11;

  localparam logic [OP_WIDTH-1:0] c_OP_LW   = OP_WIDTH'(6'b100011);
  localparam logic [OP_WIDTH-1:0] c_OP_SW   = OP_WIDTH'(6'b101011);
  localparam logic [OP_WIDTH-1:0] c_OP_RTYP = OP_WIDTH'(6'b000000);
  localparam logic [OP_WIDTH-1:0] c_OP_BEQ  = OP_WIDTH'(6'b000100);
  localparam logic [OP_WIDTH-1:0] c_OP_ADDI = OP_WIDTH'(6'b001000);
  localparam logic [OP_WIDTH-1:0] c_OP_J    = OP_WIDTH'(6'b000010);
  localparam logic [OP_WIDTH-1:0] c_OP_BNE  = OP_WIDTH'(6'b000101);
  localparam logic [7:0]          c_WAIT_MAX = 8'(WAIT_MAX);

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [7:0] r_wait;
  logic       w_memstate;
  logic       w_timeout;
  logic       w_taken;
  logic       w_pcwrite;
  logic       w_branch;

  assign w_memstate = (r_state == c_FETCH) || (r_state == c_MEMRD) || (r_state == c_MEMWR);
  // A ready response in the limit cycle beats the timeout.
  assign w_timeout  = w_memstate && !mem_ready && (r_wait == c_WAIT_MAX);

`ifdef MCCTRL_BNE_EN
  logic r_is_bne;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_is_bne <= 1'b0;
    else if (r_state == c_DECODE)
      r_is_bne <= (op == c_OP_BNE);
  end

  assign w_taken = r_is_bne ? !zero : zero;
`else
  assign w_taken = zero;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= c_FETCH;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_wait <= 8'd0;
    else if (w_memstate && !mem_ready && !w_timeout)
      r_wait <= r_wait + 8'd1;
    else
      r_wait <= 8'd0;
  end

  always_comb begin
    w_next = c_FETCH;
    case (r_state)
      c_FETCH:   w_next = mem_ready ? c_DECODE : c_FETCH;
      c_DECODE: begin
        if ((op == c_OP_LW) || (op == c_OP_SW)) w_next = c_MEMADR;
        else if (op == c_OP_RTYP)               w_next = c_RTYPEEX;
        else if (op == c_OP_BEQ)                w_next = c_BEQEX;
`ifdef MCCTRL_BNE_EN
        else if (op == c_OP_BNE)                w_next = c_BEQEX;
`endif
        else if (op == c_OP_ADDI)               w_next = c_ADDIEX;
        else if (op == c_OP_J)                  w_next = c_JEX;
        else                                    w_next = c_FETCH;
      end
      c_MEMADR:  w_next = (op == c_OP_SW) ? c_MEMWR : c_MEMRD;
      c_MEMRD:   w_next = w_timeout ? c_FETCH : (mem_ready ? c_MEMWB : c_MEMRD);
      c_MEMWR:   w_next = (mem_ready || w_timeout) ? c_FETCH : c_MEMWR;
      c_RTYPEEX: w_next = c_RTYPEWB;
      c_ADDIEX:  w_next = c_ADDIWB;
      default:   w_next = c_FETCH;
    endcase
  end

  always_comb begin
    w_pcwrite   = 1'b0;
    w_branch    = 1'b0;
    irwrite     = 1'b0;
    regwrite    = 1'b0;
    memwrite    = 1'b0;
    iord        = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsrc       = 2'b00;
    aluop       = 2'b00;
    illegal_op  = 1'b0;
    case (r_state)
      c_FETCH: begin
        alusrcb   = 2'b01;
        irwrite   = mem_ready;
        w_pcwrite = mem_ready;
      end
      c_DECODE: begin
        alusrcb    = 2'b11;
        illegal_op = (w_next == c_FETCH);
      end
      c_MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      c_MEMRD:   iord = 1'b1;
      c_MEMWB:   begin regwrite = 1'b1; memtoreg = 1'b1; end
      c_MEMWR:   begin iord = 1'b1; memwrite = !w_timeout; end
      c_RTYPEEX: begin alusrca = 1'b1; aluop = 2'b10; end
      c_RTYPEWB: begin regwrite = 1'b1; regdst = 1'b1; end
      c_BEQEX:   begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; w_branch = 1'b1; end
      c_ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      c_ADDIWB:  regwrite = 1'b1;
      c_JEX:     begin w_pcwrite = 1'b1; pcsrc = 2'b10; end
      default:   ;
    endcase
    pcen        = w_pcwrite || (w_branch && w_taken);
    mem_timeout = w_timeout;
    state_o     = r_state;
    // Nothing may escape while reset is held, including the FETCH mux selects.
    if (!rst_n) begin
      pcen = 1'b0; irwrite = 1'b0; regwrite = 1'b0; memwrite = 1'b0;
      iord = 1'b0; memtoreg = 1'b0; regdst = 1'b0; alusrca = 1'b0;
      alusrcb = 2'b00; pcsrc = 2'b00; aluop = 2'b00;
      illegal_op = 1'b0; mem_timeout = 1'b0; state_o = 4'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_ctrl
// Brief    : Scoreboard bench for the multicycle control FSM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic       illegal_op, mem_timeout;
  logic [3:0] state_o;

  mips_multicycle_ctrl #(.OP_WIDTH(6), .WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] v;
  } exp_t;

  exp_t  q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string tname   = "reset";

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, J = 6'b000010, BNE = 6'b000101, BAD = 6'b111111;

  // {state, pcen, irwrite, regwrite, memwrite, memtoreg, iord, pcsrc, alusrcb, illegal, timeout}
  function automatic logic [15:0] E(input logic [3:0] st, input logic [5:0] f,
                                    input logic [1:0] ps, input logic [1:0] sb,
                                    input logic [1:0] it);
    return {st, f, ps, sb, it};
  endfunction

  localparam logic [15:0] RST = 16'h0000;
  logic [15:0] F1, F0, FT, D, DI, MA, MR, WB, MW, MWT, RX, RW, BT, BN, AX, AW, JX;

  initial begin
    F1 = E(0, 6'b110000, 0, 1, 0);  F0 = E(0, 0, 0, 1, 0);  FT = E(0, 0, 0, 1, 2'b01);
    D  = E(1, 0, 0, 3, 0);          DI = E(1, 0, 0, 3, 2'b10);
    MA = E(2, 0, 0, 2, 0);          MR = E(3, 6'b000001, 0, 0, 0);
    WB = E(4, 6'b001010, 0, 0, 0);  MW = E(5, 6'b000101, 0, 0, 0);
    MWT = E(5, 6'b000001, 0, 0, 2'b01);
    RX = E(6, 0, 0, 0, 0);          RW = E(7, 6'b001000, 0, 0, 0);
    BT = E(8, 6'b100000, 1, 0, 0);  BN = E(8, 0, 1, 0, 0);
    AX = E(9, 0, 0, 2, 0);          AW = E(10, 6'b001000, 0, 0, 0);
    JX = E(11, 6'b100000, 2, 0, 0);
  end

  task automatic cyc(input logic r, input logic rdy, input logic z,
                     input logic [5:0] o, input logic [15:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = r; mem_ready = rdy; zero = z; op = o;
    x.name = tname;
    x.v    = e;
    q.push_back(x);
  endtask

  // Monitor: every cycle presents a full output vector, compared mid-cycle.
  initial begin
    exp_t        x;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x   = q.pop_front();
        act = {state_o, pcen, irwrite, regwrite, memwrite, memtoreg, iord,
               pcsrc, alusrcb, illegal_op, mem_timeout};
        n_tests++;
        if (act !== x.v) begin
          n_fail++;
          $display("FAIL %s: got %04h expected %04h at %0t", x.name, act, x.v, $time);
        end
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    tname = "reset_hold";
    cyc(0, 1, 0, LW, RST);
    cyc(0, 1, 0, LW, RST);
    tname = "reset_release";
    cyc(1, 1, 0, LW, F1);

    tname = "lw";
    cyc(1, 1, 0, LW, D);
    cyc(1, 1, 0, LW, MA);
    cyc(1, 1, 0, LW, MR);
    cyc(1, 1, 0, LW, WB);
    cyc(1, 1, 0, SW, F1);

    tname = "sw";
    cyc(1, 1, 0, SW, D);
    cyc(1, 1, 0, SW, MA);
    cyc(1, 1, 0, SW, MW);
    cyc(1, 1, 0, RT, F1);

    tname = "rtype";
    cyc(1, 1, 0, RT, D);
    cyc(1, 1, 0, RT, RX);
    cyc(1, 1, 0, RT, RW);
    cyc(1, 1, 0, ADDI, F1);

    tname = "addi";
    cyc(1, 1, 0, ADDI, D);
    cyc(1, 1, 0, ADDI, AX);
    cyc(1, 1, 0, ADDI, AW);
    cyc(1, 1, 0, J, F1);

    tname = "j";
    cyc(1, 1, 0, J, D);
    cyc(1, 1, 0, J, JX);
    cyc(1, 1, 0, BNE, F1);

    tname = "bne_z0";
`ifdef MCCTRL_BNE_EN
    cyc(1, 1, 0, BNE, D);
    cyc(1, 1, 0, BNE, BT);
    cyc(1, 1, 1, BEQ, F1);
`else
    cyc(1, 1, 0, BNE, DI);
    cyc(1, 1, 0, BEQ, F1);
`endif

    tname = "beq_taken";
    cyc(1, 1, 1, BEQ, D);
    cyc(1, 1, 1, BEQ, BT);
    cyc(1, 1, 0, BEQ, F1);
    tname = "beq_not_taken";
    cyc(1, 1, 0, BEQ, D);
    cyc(1, 1, 0, BEQ, BN);
    cyc(1, 1, 0, BAD, F1);

    tname = "illegal";
    cyc(1, 1, 0, BAD, DI);
    cyc(1, 0, 0, RT, F0);

    tname = "fetch_wait";
    for (int i = 0; i < 14; i++) cyc(1, 0, 0, RT, F0);
    tname = "fetch_timeout";
    cyc(1, 0, 0, RT, FT);
    tname = "fetch_wait2";
    for (int i = 0; i < 15; i++) cyc(1, 0, 0, RT, F0);
    tname = "fetch_ready_wins";
    cyc(1, 1, 0, RT, F1);
    cyc(1, 1, 0, RT, D);
    cyc(1, 1, 0, RT, RX);
    cyc(1, 1, 0, RT, RW);
    cyc(1, 1, 0, SW, F1);

    tname = "memwr_wait";
    cyc(1, 1, 0, SW, D);
    cyc(1, 1, 0, SW, MA);
    for (int i = 0; i < 15; i++) cyc(1, 0, 0, SW, MW);
    tname = "memwr_timeout";
    cyc(1, 0, 0, SW, MWT);
    cyc(1, 1, 0, LW, F1);

    tname = "reset_mid_memrd";
    cyc(1, 1, 0, LW, D);
    cyc(1, 1, 0, LW, MA);
    cyc(1, 0, 0, LW, MR);
    cyc(1, 0, 0, LW, MR);
    cyc(0, 1, 0, LW, RST);
    cyc(0, 1, 0, LW, RST);
    cyc(1, 0, 0, LW, F0);
    cyc(1, 1, 0, LW, F1);
    cyc(1, 1, 0, LW, D);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
